// File: rtl/serial_subtractor_if.sv
// Purpose: handshake and data bundle for the bit-serial subtractor.
// Signals:
//   start         request; sampled only while the subtractor is idle
//   a, b, bin     minuend, subtrahend, borrow-in; sampled with accepted start
//   busy          high while an operation is in flight (RUN and DONE)
//   done          one-cycle pulse; diff/bout/ovf valid in that cycle
//   diff          a - b - bin modulo 2^WIDTH
//   bout          final borrow-out (unsigned underflow)
//   ovf           signed two's-complement overflow
// Modports: master drives requests, slave is the subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Purpose: bit-serial WIDTH-bit subtractor computing a - b - bin one bit per
// clock, LSB first, with a single full-subtractor cell and registered borrow.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    serial_subtractor_if.slave (start/a/b/bin in, busy/done/diff/bout/ovf out)
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_load;
  logic             w_step;
  logic             w_last;

  // r_a shifts right feeding bit i at [0]; result bits refill it from the MSB,
  // so after WIDTH steps it holds the difference.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_a_next;

  // Full-subtractor cell on the current bit.
  assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_a_next = w_d;
    end else begin : g_wn
      assign w_a_next = {w_d, r_a[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load       = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST) begin
          w_last       = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Working registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_load) begin
        r_a     <= bus.a;
        r_b     <= bus.b;
        r_br    <= bus.bin;
        r_cnt   <= '0;
        r_a_msb <= bus.a[WIDTH-1];
        r_b_msb <= bus.b[WIDTH-1];
      end else if (w_step) begin
        r_a   <= w_a_next;
        r_b   <= r_b >> 1;
        r_br  <= w_br_next;
        r_cnt <= r_cnt + CW'(1);
      end
      // Overflow: operand signs differ and result sign differs from a's.
      if (w_last) begin
        r_diff <= w_a_next;
        r_bout <= w_br_next;
        r_ovf  <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
      end
      r_busy <= (w_state_next != S_IDLE);
      r_done <= w_last;
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Purpose: self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1)
// against an arithmetic reference model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(1)) if1 ();

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8.slave)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                input longint unsigned bin, output longint unsigned d,
                                output bit bo, output bit ov);
    longint unsigned mask;
    longint          full, half, sa, sb, r;
    mask = (64'd1 << w) - 64'd1;
    full = longint'(64'd1 << w);
    half = longint'(64'd1 << (w - 1));
    d    = (a - b - bin) & mask;
    bo   = (a < b + bin);
    sa   = (longint'(a) >= half) ? longint'(a) - full : longint'(a);
    sb   = (longint'(b) >= half) ? longint'(b) - full : longint'(b);
    r    = sa - sb - longint'(bin);
    ov   = (r < -half) || (r > half - 1);
  endfunction

  // One 8-bit operation; optionally pulses start with other operands mid-RUN.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit mid);
    longint unsigned d;
    bit              bo, ov, seen, stable;
    int              lat, busy_n;
    logic [7:0]      d0;
    model(8, a, b, bin, d, bo, ov);
    @(negedge clk);
    if8.start = 1'b1; if8.a = a; if8.b = b; if8.bin = bin;
    @(posedge clk); #1;
    if8.start = 1'b0;
    if8.a = 8'($urandom); if8.b = 8'($urandom); if8.bin = 1'($urandom);
    d0 = if8.diff; seen = 0; stable = 1; lat = 0; busy_n = 0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk);
      if (mid && n == 3) begin
        if8.start = 1'b1; if8.a = ~a; if8.b = a; if8.bin = ~bin;
      end
      if (mid && n == 4) if8.start = 1'b0;
      if (if8.busy) busy_n++;
      if (if8.done) begin
        seen = 1; lat = n;
      end else if (if8.diff !== d0) begin
        stable = 0;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(lat), 64'd9);
    check("busy_cycles", 64'(busy_n), 64'd9);
    check("diff_hold_in_run", 64'(stable), 64'd1);
    check("diff", 64'(if8.diff), d);
    check("bout", 64'(if8.bout), 64'(bo));
    check("ovf", 64'(if8.ovf), 64'(ov));
    @(negedge clk);
    check("done_one_cycle", 64'(if8.done), 64'd0);
    check("busy_idle", 64'(if8.busy), 64'd0);
  endtask

  task automatic op1(input logic a, input logic b, input logic bin);
    longint unsigned d;
    bit              bo, ov, seen;
    int              lat;
    model(1, 64'(a), 64'(b), 64'(bin), d, bo, ov);
    @(negedge clk);
    if1.start = 1'b1; if1.a = a; if1.b = b; if1.bin = bin;
    @(posedge clk); #1;
    if1.start = 1'b0;
    seen = 0; lat = 0;
    for (int n = 1; n <= 6 && !seen; n++) begin
      @(negedge clk);
      if (if1.done) begin
        seen = 1; lat = n;
      end
    end
    check("w1_done_seen", 64'(seen), 64'd1);
    check("w1_latency", 64'(lat), 64'd2);
    check("w1_diff", 64'(if1.diff), d);
    check("w1_bout", 64'(if1.bout), 64'(bo));
    check("w1_ovf", 64'(if1.ovf), 64'(ov));
  endtask

  // start held high for three back-to-back operations.
  task automatic held3();
    logic [7:0]      a, b;
    logic            bin;
    longint unsigned d;
    bit              bo, ov, seen;
    int              ncyc, last;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    @(negedge clk);
    if8.start = 1'b1; if8.a = a; if8.b = b; if8.bin = bin;
    ncyc = 0; last = 0;
    for (int op = 0; op < 3; op++) begin
      seen = 0;
      for (int n = 0; n < 30 && !seen; n++) begin
        @(negedge clk);
        ncyc++;
        if (if8.done) seen = 1;
      end
      check("held_done_seen", 64'(seen), 64'd1);
      if (!seen) break;
      model(8, a, b, bin, d, bo, ov);
      check("held_diff", 64'(if8.diff), d);
      check("held_bout", 64'(if8.bout), 64'(bo));
      check("held_ovf", 64'(if8.ovf), 64'(ov));
      // Done pulses: WIDTH+1 non-done cycles between them.
      if (op > 0) check("held_spacing", 64'(ncyc - last), 64'd10);
      last = ncyc;
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      if8.a = a; if8.b = b; if8.bin = bin;
      if (op == 2) if8.start = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    check("held_end_idle", 64'(if8.busy), 64'd0);
  endtask

  task automatic reset_abort();
    bit seen;
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h5A; if8.b = 8'h21; if8.bin = 1'b0;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(if8.busy), 64'd0);
    check("abort_done", 64'(if8.done), 64'd0);
    check("abort_diff", 64'(if8.diff), 64'd0);
    check("abort_bout", 64'(if8.bout), 64'd0);
    check("abort_ovf", 64'(if8.ovf), 64'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (if8.done) seen = 1;
    end
    check("abort_no_done", 64'(seen), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    if8.start = 1'b1; if8.a = 8'hAA; if8.b = 8'h55; if8.bin = 1'b1;
    if1.start = 1'b1; if1.a = 1'b0; if1.b = 1'b1; if1.bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(if8.busy), 64'd0);
    check("rst_done", 64'(if8.done), 64'd0);
    check("rst_diff", 64'(if8.diff), 64'd0);
    check("rst_bout", 64'(if8.bout), 64'd0);
    check("rst_ovf", 64'(if8.ovf), 64'd0);
    check("rst_w1_busy", 64'(if1.busy), 64'd0);
    if8.start = 1'b0; if1.start = 1'b0;
    rst_n = 1'b1;

    op8(8'd5,   8'd3,   1'b0, 1'b0);
    op8(8'd3,   8'd5,   1'b0, 1'b0);
    op8(8'h80,  8'h01,  1'b0, 1'b0);
    op8(8'h00,  8'h00,  1'b1, 1'b0);
    op8(8'h7F,  8'hFF,  1'b0, 1'b0);
    op8(8'hFF,  8'hFF,  1'b1, 1'b0);
    for (int i = 0; i < 16; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    op8(8'h9C, 8'h3B, 1'b1, 1'b1);
    op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);

    held3();

    op8(8'h7F, 8'hFF, 1'b0, 1'b0);
    reset_abort();
    op8(8'h40, 8'hC1, 1'b0, 1'b0);

    for (int v = 0; v < 8; v++) begin
      logic [2:0] t;
      t = 3'(v);
      op1(t[2], t[1], t[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
